// File: rtl/pkt_send_pkg.sv
// Shared types for the packet send scheduler.
// State encoding, port index type and default address width.
package pkt_send_pkg;

  localparam int ADDR_W_DEF = 25;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_e;

  typedef logic port_t;

endpackage

// File: rtl/pkt_send_scheduler_if.sv
// Host command and send-engine conduit bundle.
// slave is the scheduler side, master the host/engine side.
interface pkt_send_scheduler_if #(
  parameter int ADDR_W = 25,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              mac_inited;
  logic              req_valid_0;
  logic [ADDR_W-1:0] req_addr_0;
  logic              req_ready_0;
  logic              req_valid_1;
  logic [ADDR_W-1:0] req_addr_1;
  logic              req_ready_1;
  logic [ADDR_W-1:0] send_addr_0;
  logic              send_cmd_0;
  logic              send_done_0;
  logic [ADDR_W-1:0] send_addr_1;
  logic              send_cmd_1;
  logic              send_done_1;
  logic              busy;
  logic [1:0]        timeout_err;
  logic [CW-1:0]     pending_0;
  logic [CW-1:0]     pending_1;

  modport slave (
    input  mac_inited,
    input  req_valid_0, req_addr_0,
    input  req_valid_1, req_addr_1,
    input  send_done_0, send_done_1,
    output req_ready_0, req_ready_1,
    output send_addr_0, send_cmd_0,
    output send_addr_1, send_cmd_1,
    output busy, timeout_err,
    output pending_0, pending_1
  );

  modport master (
    output mac_inited,
    output req_valid_0, req_addr_0,
    output req_valid_1, req_addr_1,
    output send_done_0, send_done_1,
    input  req_ready_0, req_ready_1,
    input  send_addr_0, send_cmd_0,
    input  send_addr_1, send_cmd_1,
    input  busy, timeout_err,
    input  pending_0, pending_1
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO for queued send commands.
// Push is ignored when full, pop is ignored when empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pkt_send_scheduler.sv
// Serialises two host command queues onto the two send engines,
// one packet at a time, since both engines share one packet RAM.
module pkt_send_scheduler
  import pkt_send_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 12
) (
  input logic                clk,
  input logic                reset,
  pkt_send_scheduler_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TB = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = (TB < 16) ? 16 : TB;
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  state_e            state_q, state_d;
  port_t             grant_q, grant_d;
  port_t             last_q, last_d;
  port_t             g;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [1:0]        terr;
  logic              done_g;

  logic              pop_0, pop_1;
  logic              full_0, full_1;
  logic              empty_0, empty_1;
  logic [ADDR_W-1:0] head_0, head_1;
  logic [CW-1:0]     count_0, count_1;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_fifo_0 (
    .clk   (clk),
    .reset (reset),
    .push  (bus.req_valid_0),
    .din   (bus.req_addr_0),
    .pop   (pop_0),
    .dout  (head_0),
    .full  (full_0),
    .empty (empty_0),
    .count (count_0)
  );

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_fifo_1 (
    .clk   (clk),
    .reset (reset),
    .push  (bus.req_valid_1),
    .din   (bus.req_addr_1),
    .pop   (pop_1),
    .dout  (head_1),
    .full  (full_1),
    .empty (empty_1),
    .count (count_1)
  );

  assign done_g = grant_q ? bus.send_done_1 : bus.send_done_0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    cmd_d   = '0;
    terr    = '0;
    pop_0   = 1'b0;
    pop_1   = 1'b0;
    g       = 1'b0;
    unique case (state_q)
      WAIT_INIT: begin
        if (bus.mac_inited) state_d = IDLE;
      end
      IDLE: begin
        if (!bus.mac_inited) begin
          state_d = WAIT_INIT;
        end else if (!empty_0 || !empty_1) begin
          // Alternate only when both ports have work queued
          g       = (!empty_0 && !empty_1) ? !last_q : empty_0;
          grant_d = g;
          last_d  = g;
          cmd_d[g] = 1'b1;
          if (g) begin
            pop_1   = 1'b1;
            addr1_d = head_1;
          end else begin
            pop_0   = 1'b1;
            addr0_d = head_0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = TW'(TIMEOUT_CYCLES);
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_g) begin
          gcnt_d  = GW'(GAP_CYCLES);
          state_d = GAP;
        end else if (tcnt_q == '0) begin
          terr[grant_q] = 1'b1;
          gcnt_d  = GW'(GAP_CYCLES);
          state_d = GAP;
        end else begin
          tcnt_d = tcnt_q - TW'(1);
        end
      end
      GAP: begin
        if (gcnt_q == '0) state_d = IDLE;
        else gcnt_d = gcnt_q - GW'(1);
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_INIT;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      cmd_q   <= cmd_d;
    end
  end

  assign bus.req_ready_0 = !full_0;
  assign bus.req_ready_1 = !full_1;
  assign bus.pending_0   = count_0;
  assign bus.pending_1   = count_1;
  assign bus.send_addr_0 = addr0_q;
  assign bus.send_addr_1 = addr1_q;
  assign bus.send_cmd_0  = cmd_q[0];
  assign bus.send_cmd_1  = cmd_q[1];
  assign bus.timeout_err = terr;
  assign bus.busy = (state_q == ISSUE) ||
                    (state_q == WAIT_DONE) ||
                    (state_q == GAP);

endmodule

// File: tb/tb_pkt_send_scheduler.sv
// Scenario tasks plus a randomized run against a timeline model
// of queue contents, grant order, completion and gap timing.
module tb_pkt_send_scheduler;
  localparam int AW = 25;
  localparam int DP = 4;
  localparam int TO = 8;
  localparam int GP = 12;
  localparam logic [62:0] RST_SNAP = {2'b11, 61'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pkt_send_scheduler_if #(.ADDR_W(AW), .DEPTH(DP)) bus ();

  pkt_send_scheduler #(
    .ADDR_W(AW), .DEPTH(DP),
    .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [62:0] snap();
    return {bus.req_ready_1, bus.req_ready_0,
            bus.pending_1, bus.pending_0,
            bus.send_cmd_1, bus.send_cmd_0,
            bus.busy, bus.timeout_err,
            bus.send_addr_1, bus.send_addr_0};
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    bus.send_done_0 = 1'b0;
    bus.send_done_1 = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input int p, input logic [AW-1:0] a);
    go();
    if (p == 0) begin
      bus.req_valid_0 = 1'b1;
      bus.req_addr_0  = a;
    end else begin
      bus.req_valid_1 = 1'b1;
      bus.req_addr_1  = a;
    end
    smp();
  endtask

  task automatic do_reset(input logic mac);
    go();
    reset = 1'b1;
    bus.mac_inited = mac;
    smp();
    go();
    smp();
    go();
    reset = 1'b0;
    smp();
  endtask

  task automatic wait_cmd(output int p, output logic [AW-1:0] a,
                          output int at, input int bound);
    p = -1;
    a = '0;
    at = -1;
    for (int k = 0; k < bound && p < 0; k++) begin
      go();
      smp();
      if (bus.send_cmd_0) begin
        p = 0; a = bus.send_addr_0; at = cyc;
      end else if (bus.send_cmd_1) begin
        p = 1; a = bus.send_addr_1; at = cyc;
      end
    end
  endtask

  task automatic pulse_done(input int p, input int n);
    repeat (n - 1) begin
      go();
      smp();
    end
    go();
    if (p == 0) bus.send_done_0 = 1'b1;
    else bus.send_done_1 = 1'b1;
    smp();
  endtask

  task automatic test_reset();
    bus.mac_inited  = 1'b0;
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    bus.req_addr_0  = '0;
    bus.req_addr_1  = '0;
    bus.send_done_0 = 1'b0;
    bus.send_done_1 = 1'b0;
    smp();
    checks++;
    if (snap() !== RST_SNAP) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h", snap(), RST_SNAP);
    end
    go();
    reset = 1'b0;
    smp();
    go();
    smp();
    checks++;
    if (snap() !== RST_SNAP) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", snap(), RST_SNAP);
    end
  endtask

  task automatic test_wait_init();
    int p, at, m;
    logic [AW-1:0] a;
    logic saw;
    do_reset(1'b0);
    push(0, 25'h0000100);
    saw = 1'b0;
    repeat (50) begin
      go();
      smp();
      if (bus.send_cmd_0 || bus.send_cmd_1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL wait_init_hold: got cmd=%0b expected 0", saw);
    end
    checks++;
    if (bus.pending_0 !== 3'd1) begin
      failures++;
      $display("FAIL wait_init_pending: got %0d expected 1", bus.pending_0);
    end
    go();
    bus.mac_inited = 1'b1;
    m = cyc;
    smp();
    wait_cmd(p, a, at, 10);
    checks++;
    if (p !== 0 || a !== 25'h0000100) begin
      failures++;
      $display("FAIL wait_init_issue: got port %0d addr %h expected 0 100", p, a);
    end
    checks++;
    if (at - m !== 2) begin
      failures++;
      $display("FAIL wait_init_latency: got %0d expected 2", at - m);
    end
  endtask

  task automatic test_fifo_full();
    int p, at;
    logic [AW-1:0] a;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      go();
      bus.req_valid_0 = 1'b1;
      bus.req_addr_0  = 25'h1000 + AW'(i);
      smp();
      checks++;
      if (bus.req_ready_0 !== 1'(i < 4)) begin
        failures++;
        $display("FAIL full_ready[%0d]: got %0b expected %0b", i, bus.req_ready_0, i < 4);
      end
    end
    go();
    smp();
    checks++;
    if (bus.pending_0 !== 3'd4 || bus.req_ready_0 !== 1'b0) begin
      failures++;
      $display("FAIL full_pending: got %0d/%0b expected 4/0", bus.pending_0, bus.req_ready_0);
    end
    go();
    bus.mac_inited = 1'b1;
    smp();
    for (int k = 0; k < 4; k++) begin
      wait_cmd(p, a, at, 40);
      checks++;
      if (p !== 0 || a !== 25'h1000 + AW'(k)) begin
        failures++;
        $display("FAIL full_drain[%0d]: got port %0d addr %h expected 0 %h", k, p, a, 25'h1000 + AW'(k));
      end
      pulse_done(0, 3);
    end
    wait_cmd(p, a, at, 40);
    checks++;
    if (p !== -1) begin
      failures++;
      $display("FAIL full_no_fifth: got port %0d addr %h expected none", p, a);
    end
  endtask

  task automatic test_round_robin();
    int p, at, prev;
    logic [AW-1:0] a;
    int ep [4] = '{0, 1, 0, 1};
    logic [AW-1:0] ea [4] = '{25'h10, 25'h30, 25'h20, 25'h40};
    do_reset(1'b0);
    for (int i = 0; i < 2; i++) begin
      go();
      bus.req_valid_0 = 1'b1;
      bus.req_addr_0  = ea[2*i];
      bus.req_valid_1 = 1'b1;
      bus.req_addr_1  = ea[2*i+1];
      smp();
    end
    go();
    bus.mac_inited = 1'b1;
    smp();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_cmd(p, a, at, 60);
      checks++;
      if (p !== ep[k] || a !== ea[k]) begin
        failures++;
        $display("FAIL rr_order[%0d]: got port %0d addr %h expected %0d %h", k, p, a, ep[k], ea[k]);
      end
      if (k > 0) begin
        checks++;
        if (at - prev !== 5 + GP + 3) begin
          failures++;
          $display("FAIL rr_spacing[%0d]: got %0d expected %0d", k, at - prev, 5 + GP + 3);
        end
      end
      prev = at;
      pulse_done((p < 0) ? 0 : p, 5);
    end
  endtask

  task automatic test_timeout();
    int p, c0, c1, te;
    logic [1:0] tv;
    logic [AW-1:0] a;
    do_reset(1'b1);
    go();
    smp();
    push(0, 25'h55);
    push(0, 25'h66);
    wait_cmd(p, a, c0, 10);
    checks++;
    if (p !== 0 || a !== 25'h55) begin
      failures++;
      $display("FAIL to_first: got port %0d addr %h expected 0 55", p, a);
    end
    te = 0;
    tv = '0;
    for (int k = 1; k <= 20 && te == 0; k++) begin
      go();
      smp();
      if (bus.timeout_err !== 2'b00) begin
        te = k;
        tv = bus.timeout_err;
      end
    end
    checks++;
    if (te !== 9 || tv !== 2'b01) begin
      failures++;
      $display("FAIL to_pulse: got delay %0d err %b expected 9 01", te, tv);
    end
    go();
    smp();
    checks++;
    if (bus.timeout_err !== 2'b00) begin
      failures++;
      $display("FAIL to_one_cycle: got %b expected 00", bus.timeout_err);
    end
    wait_cmd(p, a, c1, 30);
    checks++;
    if (p !== 0 || a !== 25'h66 || c1 - (c0 + 9) !== GP + 3) begin
      failures++;
      $display("FAIL to_next: got port %0d addr %h gap %0d expected 0 66 %0d", p, a, c1 - (c0 + 9), GP + 3);
    end
  endtask

  task automatic test_ignore_other();
    int p, c0, c1;
    logic [AW-1:0] a;
    do_reset(1'b1);
    go();
    smp();
    push(0, 25'h77);
    push(0, 25'h88);
    wait_cmd(p, a, c0, 10);
    go();
    bus.send_done_1 = 1'b1;
    smp();
    go();
    bus.send_done_1 = 1'b1;
    smp();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL other_busy: got %0b expected 1", bus.busy);
    end
    pulse_done(0, 3);
    wait_cmd(p, a, c1, 30);
    checks++;
    if (p !== 0 || a !== 25'h88 || c1 - c0 !== 5 + GP + 3) begin
      failures++;
      $display("FAIL other_ignored: got port %0d addr %h spacing %0d expected 0 88 %0d", p, a, c1 - c0, 5 + GP + 3);
    end
  endtask

  task automatic test_reset_mid();
    logic saw;
    do_reset(1'b1);
    go();
    smp();
    for (int i = 0; i < 4; i++) push(0, 25'hA + AW'(i));
    go();
    smp();
    checks++;
    if (bus.busy !== 1'b1 || bus.pending_0 !== 3'd3) begin
      failures++;
      $display("FAIL mid_setup: got busy %0b pending %0d expected 1 3", bus.busy, bus.pending_0);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (snap() !== RST_SNAP) begin
      failures++;
      $display("FAIL mid_reset_now: got %h expected %h", snap(), RST_SNAP);
    end
    smp();
    checks++;
    if (snap() !== RST_SNAP) begin
      failures++;
      $display("FAIL mid_reset_next: got %h expected %h", snap(), RST_SNAP);
    end
    go();
    reset = 1'b0;
    smp();
    saw = 1'b0;
    repeat (30) begin
      go();
      smp();
      if (bus.send_cmd_0 || bus.send_cmd_1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || bus.pending_0 !== 3'd0) begin
      failures++;
      $display("FAIL mid_lost: got cmd %0b pending %0d expected 0 0", saw, bus.pending_0);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] mq0 [$];
    logic [AW-1:0] mq1 [$];
    logic [AW-1:0] ea0, ea1, a0, a1;
    logic [62:0] exp;
    logic v0, v1, d0, d1, dg, c0, c1, bz, r0, r1, acc0, acc1;
    logic [1:0] te;
    int out, g, iss, dn_at, dn_p, idle_from, lg;
    do_reset(1'b1);
    go();
    smp();
    go();
    smp();
    ea0 = '0; ea1 = '0;
    out = 0; g = 0; iss = -100; dn_at = -100; dn_p = 0;
    idle_from = 0; lg = 1;
    for (int i = 0; i < 800; i++) begin
      go();
      v0 = ($urandom_range(0, 9) == 0);
      v1 = ($urandom_range(0, 9) == 0);
      a0 = AW'($urandom);
      a1 = AW'($urandom);
      d0 = (dn_p == 0 && i == dn_at);
      d1 = (dn_p == 1 && i == dn_at);
      if (out != 0 && $urandom_range(0, 5) == 0) begin
        if (g == 0) d1 = 1'b1;
        else d0 = 1'b1;
      end else if (out == 0 && $urandom_range(0, 7) == 0) begin
        d0 = 1'b1;
        d1 = $urandom_range(0, 1) == 1;
      end
      bus.req_valid_0 = v0;
      bus.req_addr_0  = a0;
      bus.req_valid_1 = v1;
      bus.req_addr_1  = a1;
      bus.send_done_0 = d0;
      bus.send_done_1 = d1;
      smp();
      dg = (g == 0) ? d0 : d1;
      r0 = mq0.size() < DP;
      r1 = mq1.size() < DP;
      c0 = (out != 0 && iss == i && g == 0);
      c1 = (out != 0 && iss == i && g == 1);
      te = '0;
      if (out != 0 && i == iss + TO + 1 && !dg) te[g] = 1'b1;
      bz = (out != 0 && i >= iss) || (out == 0 && i < idle_from);
      exp = {r1, r0, 3'(mq1.size()), 3'(mq0.size()),
             c1, c0, bz, te, ea1, ea0};
      checks++;
      if (snap() !== exp) begin
        failures++;
        $display("FAIL rand[%0d]: got %h expected %h", i, snap(), exp);
      end
      if (out != 0 && i > iss && (dg || i == iss + TO + 1)) begin
        out = 0;
        idle_from = i + GP + 2;
      end
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      if (out == 0 && i >= idle_from && (mq0.size() + mq1.size()) > 0) begin
        if (mq0.size() > 0 && mq1.size() > 0) g = 1 - lg;
        else g = (mq0.size() > 0) ? 0 : 1;
        lg = g;
        if (g == 0) ea0 = mq0.pop_front();
        else ea1 = mq1.pop_front();
        out = 1;
        iss = i + 1;
        dn_p = g;
        dn_at = iss + $urandom_range(0, 11);
      end
      if (acc0) mq0.push_back(a0);
      if (acc1) mq1.push_back(a1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wait_init();
    test_fifo_full();
    test_round_robin();
    test_timeout();
    test_ignore_other();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
